// File: rtl/pic8259_control_unit.sv
// 8259 control core: ICW/OCW decode, mode and mask registers, INT/INTA
// handshake, cascade addressing and interrupt vector drive onto DATA.
module pic8259_control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RD_ENABLE,
  input  logic       WR_ENABLE,
  inout  wire  [7:0] DATA,
  input  logic       A0,
  input  logic       INTERNAL_INT,
  input  logic       INTA_,
  input  logic       SP_,
  input  logic [2:0] CAS_IN,
  output logic [2:0] CAS_OUT,
  input  logic [2:0] IR_NUM,
  output logic [7:0] interrupt_mask,
  output logic       INT,
  output logic       AEOI,
  output logic [1:0] INTA_COUNT,
  output logic       R,
  output logic       sngl,
  output logic       LEVEL,
  output logic       RIRR,
  output logic       RISR
);

  // state      | meaning
  // WAIT_ICW1  | uninitialised, only ICW1 accepted
  // WAIT_ICW2  | expecting vector base
  // WAIT_ICW3  | expecting cascade configuration
  // WAIT_ICW4  | expecting mode word
  // READY      | initialised, OCWs and INTA handshake active
  typedef enum logic [2:0] {
    WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY
  } state_t;

  state_t      state_q;
  logic        wr_prev_q, inta_prev_q;
  logic        level_q, sngl_q, ic4_q, aeoi_q, r_q, rirr_q, risr_q, int_q;
  logic [7:0]  mask_q, icw3_q;
  logic [4:0]  t_q;
  logic [1:0]  cnt_q;

  logic        wr_rise, inta_fall, inta_rise;
  logic        master, owns_vector, vec_en, mask_en;
  logic [7:0]  vector;

  assign wr_rise   = WR_ENABLE & ~wr_prev_q;
  assign inta_fall = ~INTA_ & inta_prev_q;
  assign inta_rise = INTA_ & ~inta_prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= WAIT_ICW1;
      wr_prev_q   <= 1'b0;
      inta_prev_q <= 1'b1;
      level_q     <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      aeoi_q      <= 1'b0;
      r_q         <= 1'b0;
      rirr_q      <= 1'b0;
      risr_q      <= 1'b0;
      int_q       <= 1'b0;
      mask_q      <= 8'h00;
      icw3_q      <= 8'h00;
      t_q         <= 5'd0;
      cnt_q       <= 2'd0;
    end else begin
      wr_prev_q   <= WR_ENABLE;
      inta_prev_q <= INTA_;

      if (state_q == READY) begin
        if (inta_fall && cnt_q != 2'd2)
          cnt_q <= cnt_q + 2'd1;
        if (inta_rise && cnt_q == 2'd2) begin
          cnt_q <= 2'd0;
          int_q <= 1'b0;
        end else if (cnt_q == 2'd0) begin
          int_q <= INTERNAL_INT;
        end
      end else begin
        cnt_q <= 2'd0;
        int_q <= 1'b0;
      end

      // ICW1 is recognised in every state and aborts any INTA sequence
      if (wr_rise) begin
        if (!A0 && DATA[4]) begin
          level_q <= DATA[3];
          sngl_q  <= DATA[1];
          ic4_q   <= DATA[0];
          mask_q  <= 8'h00;
          r_q     <= 1'b0;
          aeoi_q  <= 1'b0;
          rirr_q  <= 1'b1;
          risr_q  <= 1'b0;
          cnt_q   <= 2'd0;
          int_q   <= 1'b0;
          state_q <= WAIT_ICW2;
        end else begin
          case (state_q)
            WAIT_ICW2: if (A0) begin
              t_q <= DATA[7:3];
              if (!sngl_q)    state_q <= WAIT_ICW3;
              else if (ic4_q) state_q <= WAIT_ICW4;
              else            state_q <= READY;
            end
            WAIT_ICW3: if (A0) begin
              icw3_q  <= DATA;
              state_q <= ic4_q ? WAIT_ICW4 : READY;
            end
            WAIT_ICW4: if (A0) begin
              aeoi_q  <= DATA[1];
              state_q <= READY;
            end
            READY: begin
              if (A0) begin
                mask_q <= DATA;
              end else if (!DATA[4] && !DATA[3]) begin
                r_q <= DATA[7];
              end else if (!DATA[4] && DATA[3] && DATA[1]) begin
                rirr_q <= ~DATA[0];
                risr_q <= DATA[0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign master      = SP_ & ~sngl_q;
  assign owns_vector = sngl_q | (SP_ & ~icw3_q[IR_NUM]) | (~SP_ & (CAS_IN == icw3_q[2:0]));
  assign vector      = {t_q, IR_NUM};
  assign vec_en      = (cnt_q == 2'd2) & ~INTA_ & RD_ENABLE & owns_vector;
  assign mask_en     = INTA_ & RD_ENABLE & A0 & (state_q == READY);

  assign DATA    = vec_en ? vector : (mask_en ? mask_q : 8'hzz);
  assign CAS_OUT = (master && cnt_q != 2'd0 && icw3_q[IR_NUM]) ? IR_NUM : 3'd0;

  assign interrupt_mask = mask_q;
  assign INT            = int_q;
  assign AEOI           = aeoi_q;
  assign INTA_COUNT     = cnt_q;
  assign R              = r_q;
  assign sngl           = sngl_q;
  assign LEVEL          = level_q;
  assign RIRR           = rirr_q;
  assign RISR           = risr_q;

endmodule

// File: tb/tb_pic8259_control_unit.sv
// Directed bench for pic8259_control_unit; an undriven DATA bus is pulled
// up, so high-Z reads back as 8'hFF (test vectors avoid that value).
module tb_pic8259_control_unit;

  logic       clk = 1'b0;
  logic       rst, rd_en, wr_en, a0, internal_int, inta_n, sp_n;
  logic [2:0] cas_in, ir_num;
  logic [2:0] cas_out;
  logic [7:0] mask;
  logic       int_o, aeoi, r_o, sngl_o, level_o, rirr, risr;
  logic [1:0] inta_count;
  logic [7:0] tb_d;
  logic       tb_oe;
  wire  [7:0] data_bus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign data_bus = tb_oe ? tb_d : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  pic8259_control_unit dut (
    .CLK(clk), .RST(rst), .RD_ENABLE(rd_en), .WR_ENABLE(wr_en), .DATA(data_bus),
    .A0(a0), .INTERNAL_INT(internal_int), .INTA_(inta_n), .SP_(sp_n),
    .CAS_IN(cas_in), .CAS_OUT(cas_out), .IR_NUM(ir_num), .interrupt_mask(mask),
    .INT(int_o), .AEOI(aeoi), .INTA_COUNT(inta_count), .R(r_o), .sngl(sngl_o),
    .LEVEL(level_o), .RIRR(rirr), .RISR(risr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic addr, input logic [7:0] d);
    a0 = addr; tb_d = d; tb_oe = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; tb_oe = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL reset_int got=%b exp=0", int_o); end
    checks++; if (inta_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", inta_count); end
    checks++; if ({mask, aeoi, r_o, sngl_o, level_o, rirr, risr, cas_out} !== 17'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {mask, aeoi, r_o, sngl_o, level_o, rirr, risr, cas_out}); end
    rd_en = 1'b1; a0 = 1'b1; #1;
    checks++; if (data_bus !== 8'hFF) begin failures++; $display("FAIL reset_data_hiz got=%h exp=ff", data_bus); end
    rd_en = 1'b0;
  endtask

  task automatic test_single_init();
    wr(1'b0, 8'h13);
    checks++; if ({sngl_o, level_o, rirr, risr} !== 4'b1010) begin
      failures++; $display("FAIL icw1_bits got=%b exp=1010", {sngl_o, level_o, rirr, risr}); end
    wr(1'b1, 8'hF8);
    rd_en = 1'b1; a0 = 1'b1; #1;
    checks++; if (data_bus !== 8'hFF) begin failures++; $display("FAIL not_ready_mask_read got=%h exp=ff", data_bus); end
    rd_en = 1'b0;
    wr(1'b1, 8'h21);
    checks++; if (aeoi !== 1'b0) begin failures++; $display("FAIL icw4_aeoi got=%b exp=0", aeoi); end
    rd_en = 1'b1; a0 = 1'b1; #1;
    checks++; if (data_bus !== 8'h00) begin failures++; $display("FAIL ready_mask_read got=%h exp=00", data_bus); end
    rd_en = 1'b0;
  endtask

  task automatic test_inta_single();
    internal_int = 1'b1; ir_num = 3'd3; a0 = 1'b0;
    tick();
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL int_assert got=%b exp=1", int_o); end
    inta_n = 1'b0; tick();
    checks++; if (inta_count !== 2'd1) begin failures++; $display("FAIL inta1_count got=%0d exp=1", inta_count); end
    checks++; if (cas_out !== 3'd0) begin failures++; $display("FAIL single_cas got=%0d exp=0", cas_out); end
    inta_n = 1'b1; tick();
    checks++; if (inta_count !== 2'd1) begin failures++; $display("FAIL inta1_high_count got=%0d exp=1", inta_count); end
    rd_en = 1'b1; inta_n = 1'b0; tick();
    checks++; if (inta_count !== 2'd2) begin failures++; $display("FAIL inta2_count got=%0d exp=2", inta_count); end
    checks++; if (data_bus !== 8'hFB) begin failures++; $display("FAIL single_vector got=%h exp=fb", data_bus); end
    rd_en = 1'b0; inta_n = 1'b1; tick();
    checks++; if ({int_o, inta_count} !== 3'b000) begin failures++; $display("FAIL seq_end got=%b exp=000", {int_o, inta_count}); end
    tick();
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL int_reassert got=%b exp=1", int_o); end
    internal_int = 1'b0; tick();
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL int_follow_low got=%b exp=0", int_o); end
  endtask

  task automatic test_ocw();
    wr(1'b1, 8'h40);
    checks++; if (mask !== 8'h40) begin failures++; $display("FAIL ocw1_mask got=%h exp=40", mask); end
    rd_en = 1'b1; a0 = 1'b1; #1;
    checks++; if (data_bus !== 8'h40) begin failures++; $display("FAIL mask_read got=%h exp=40", data_bus); end
    rd_en = 1'b0;
    wr(1'b0, 8'hA0);
    checks++; if (r_o !== 1'b1) begin failures++; $display("FAIL ocw2_r got=%b exp=1", r_o); end
    wr(1'b0, 8'h0B);
    checks++; if ({rirr, risr} !== 2'b01) begin failures++; $display("FAIL ocw3_risr got=%b exp=01", {rirr, risr}); end
    wr(1'b0, 8'h08);
    checks++; if ({rirr, risr} !== 2'b01) begin failures++; $display("FAIL ocw3_nochange got=%b exp=01", {rirr, risr}); end
    a0 = 1'b1; tb_d = 8'h55; tb_oe = 1'b1; wr_en = 1'b1;
    tick(); tick();
    tb_d = 8'h66; tick(); tick();
    wr_en = 1'b0; tb_oe = 1'b0; tick();
    checks++; if (mask !== 8'h55) begin failures++; $display("FAIL long_strobe_once got=%h exp=55", mask); end
  endtask

  task automatic test_cascade_master();
    sp_n = 1'b1;
    wr(1'b0, 8'h11);
    checks++; if ({sngl_o, r_o, mask} !== 10'd0) begin failures++; $display("FAIL icw1_clears got=%h exp=0", {sngl_o, r_o, mask}); end
    wr(1'b1, 8'h20); wr(1'b1, 8'h04); wr(1'b1, 8'h03);
    checks++; if (aeoi !== 1'b1) begin failures++; $display("FAIL master_aeoi got=%b exp=1", aeoi); end
    internal_int = 1'b1; ir_num = 3'd2; a0 = 1'b0; tick();
    checks++; if (cas_out !== 3'd0) begin failures++; $display("FAIL cas_idle got=%0d exp=0", cas_out); end
    inta_n = 1'b0; tick();
    checks++; if (cas_out !== 3'd2) begin failures++; $display("FAIL cas_slave_ir got=%0d exp=2", cas_out); end
    inta_n = 1'b1; tick();
    rd_en = 1'b1; inta_n = 1'b0; tick();
    checks++; if (data_bus !== 8'hFF) begin failures++; $display("FAIL master_hiz got=%h exp=ff", data_bus); end
    checks++; if (cas_out !== 3'd2) begin failures++; $display("FAIL cas_hold got=%0d exp=2", cas_out); end
    rd_en = 1'b0; inta_n = 1'b1; tick();
    checks++; if (cas_out !== 3'd0) begin failures++; $display("FAIL cas_end got=%0d exp=0", cas_out); end
    tick();
    ir_num = 3'd5;
    inta_n = 1'b0; tick();
    checks++; if (cas_out !== 3'd0) begin failures++; $display("FAIL cas_no_slave got=%0d exp=0", cas_out); end
    inta_n = 1'b1; tick();
    rd_en = 1'b1; inta_n = 1'b0; tick();
    checks++; if (data_bus !== 8'h25) begin failures++; $display("FAIL master_vector got=%h exp=25", data_bus); end
    rd_en = 1'b0; inta_n = 1'b1; tick();
  endtask

  task automatic test_slave();
    sp_n = 1'b0;
    wr(1'b0, 8'h19);
    checks++; if ({level_o, sngl_o, aeoi} !== 3'b100) begin failures++; $display("FAIL slave_icw1 got=%b exp=100", {level_o, sngl_o, aeoi}); end
    wr(1'b1, 8'h48); wr(1'b1, 8'h02); wr(1'b1, 8'h01);
    internal_int = 1'b1; ir_num = 3'd6; cas_in = 3'd2; a0 = 1'b0; tick();
    inta_n = 1'b0; tick();
    checks++; if (cas_out !== 3'd0) begin failures++; $display("FAIL slave_cas got=%0d exp=0", cas_out); end
    inta_n = 1'b1; tick();
    rd_en = 1'b1; inta_n = 1'b0; tick();
    checks++; if (data_bus !== 8'h4E) begin failures++; $display("FAIL slave_vector got=%h exp=4e", data_bus); end
    cas_in = 3'd1; #1;
    checks++; if (data_bus !== 8'hFF) begin failures++; $display("FAIL slave_other_id got=%h exp=ff", data_bus); end
    rd_en = 1'b0; inta_n = 1'b1; tick(); tick();
  endtask

  task automatic test_icw1_mid_sequence();
    inta_n = 1'b0; tick();
    checks++; if (inta_count !== 2'd1) begin failures++; $display("FAIL pre_icw1_count got=%0d exp=1", inta_count); end
    wr(1'b0, 8'h13);
    checks++; if ({int_o, inta_count} !== 3'b000) begin failures++; $display("FAIL icw1_abort got=%b exp=000", {int_o, inta_count}); end
    inta_n = 1'b1; tick();
  endtask

  task automatic test_rst_mid_sequence();
    sp_n = 1'b1;
    wr(1'b0, 8'h13); wr(1'b1, 8'hF8); wr(1'b1, 8'h21); wr(1'b1, 8'h40);
    internal_int = 1'b1; ir_num = 3'd3; tick();
    inta_n = 1'b0; tick();
    checks++; if (inta_count !== 2'd1) begin failures++; $display("FAIL pre_rst_count got=%0d exp=1", inta_count); end
    rst = 1'b1; tick(); inta_n = 1'b1; tick(); rst = 1'b0;
    checks++; if ({int_o, inta_count, mask, sngl_o, rirr} !== 13'd0) begin
      failures++; $display("FAIL rst_mid got=%h exp=0", {int_o, inta_count, mask, sngl_o, rirr}); end
    wr(1'b1, 8'h77);
    checks++; if (mask !== 8'h00) begin failures++; $display("FAIL ocw1_before_icw1 got=%h exp=00", mask); end
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL int_not_ready got=%b exp=0", int_o); end
    rd_en = 1'b1; a0 = 1'b1; #1;
    checks++; if (data_bus !== 8'hFF) begin failures++; $display("FAIL rst_data_hiz got=%h exp=ff", data_bus); end
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; a0 = 1'b0; internal_int = 1'b0;
    inta_n = 1'b1; sp_n = 1'b1; cas_in = 3'd0; ir_num = 3'd0; tb_d = 8'h00; tb_oe = 1'b0;
    test_reset();
    test_single_init();
    test_inta_single();
    test_ocw();
    test_cascade_master();
    test_slave();
    test_icw1_mid_sequence();
    test_rst_mid_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
